// File: rtl/alu_pipe.sv
// Registered, handshaked ALU: 8-function arithmetic/logic group, shift/rotate group,
// and a multi-cycle shift-add multiplier, with result and flags held behind valid/ready.
module alu_pipe #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   ctrl,
  input  logic         cin,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] f,
  output logic         cout,
  output logic         v,
  output logic         z,
  output logic         n
);

  localparam int SW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  typedef struct packed {
    logic [N-1:0] f;
    logic         cout;
    logic         v;
  } res_t;

  state_t          state, state_nxt;
  logic [SW-1:0]   cnt;
  logic [2*N-1:0]  acc;
  logic [2*N-1:0]  mcand;
  logic [N-1:0]    mplier;
  logic [2*N-1:0]  acc_sum;

  logic            accept;
  logic            is_mul_op;
  logic            mul_last;

  logic [N-1:0]    b_eff;
  logic [N:0]      sum;
  logic            c_msb;
  logic [SW-1:0]   s;
  logic [SW:0]     rot_amt;
  res_t            alu_res;

  // Handshake: in_ready depends only on state and out_ready, never on operands.
  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign is_mul_op = mode && (ctrl == 2'b10) && !cin;
  assign mul_last  = (state == MUL) && (cnt == SW'(N - 1));
  assign s         = b[SW-1:0];

  // One partial product per cycle: multiplicand shifts left, multiplier shifts right.
  assign acc_sum = acc + (mplier[0] ? mcand : '0);

  // Next-state logic.
  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_mul_op ? MUL : HOLD;
      MUL:  if (mul_last) state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (accept) state_nxt = is_mul_op ? MUL : HOLD;
          else        state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Single-cycle result, computed from the operands presented on the accepting edge.
  always_comb begin
    b_eff   = cin ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{N{1'b0}}, cin};
    // Carry into the MSB recovered from the MSB sum bit and its two operand bits.
    c_msb   = a[N-1] ^ b_eff[N-1] ^ sum[N-1];
    rot_amt = (SW+1)'(N) - {1'b0, s};
    alu_res = '0;
    if (!mode) begin
      case (ctrl)
        2'b00: begin
          alu_res.f    = sum[N-1:0];
          alu_res.cout = sum[N];
          alu_res.v    = c_msb ^ sum[N];
        end
        2'b01:   alu_res.f = a | b_eff;
        2'b10:   alu_res.f = a & b_eff;
        default: alu_res.f = cin ? ~b : ~a;
      endcase
    end else begin
      case ({ctrl, cin})
        3'b000:  alu_res.f = a << s;
        3'b001:  alu_res.f = a >> s;
        3'b010:  alu_res.f = $signed(a) >>> s;
        // rot_amt == N when s == 0, so the right-shift term vanishes.
        3'b011:  alu_res.f = (a << s) | (a >> rot_amt);
        default: alu_res.f = a;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      // NOTE: the multiplier working registers are reset too, so nothing is X after reset even mid-multiply.
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      f      <= '0;
      cout   <= 1'b0;
      v      <= 1'b0;
      z      <= 1'b0;
      n      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (is_mul_op) begin
          acc    <= '0;
          mcand  <= {{N{1'b0}}, a};
          mplier <= b;
          cnt    <= '0;
        end else begin
          f    <= alu_res.f;
          cout <= alu_res.cout;
          v    <= alu_res.v;
          z    <= (alu_res.f == '0);
          n    <= alu_res.f[N-1];
        end
      end else if (state == MUL) begin
        acc    <= acc_sum;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
        if (mul_last) begin
          f    <= acc_sum[N-1:0];
          cout <= |acc_sum[2*N-1:N];
          v    <= |acc_sum[2*N-1:N];
          z    <= (acc_sum[N-1:0] == '0);
          n    <= acc_sum[N-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe: directed spec cases plus randomized traffic with
// random backpressure, checked against a plain-arithmetic reference model.
module tb_alu_pipe;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic [1:0]   ctrl = '0;
  logic         cin = 1'b0;
  logic         mode = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [N-1:0] f;
  logic         cout, v, z, n;

  typedef struct packed {
    logic [N-1:0] f;
    logic         cout;
    logic         v;
    logic         z;
    logic         n;
  } exp_t;

  exp_t sb_q[$];
  exp_t held;
  exp_t popped;
  bit   stalled = 1'b0;
  bit   rand_rdy = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  alu_pipe #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ctrl(ctrl), .cin(cin), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .cout(cout), .v(v), .z(z), .n(n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(input logic [N-1:0] ef, input logic ec, ev, ez, en);
    exp_t e;
    e.f = ef; e.cout = ec; e.v = ev; e.z = ez; e.n = en;
    return e;
  endfunction

  function automatic exp_t dut_res();
    return mk(f, cout, v, z, n);
  endfunction

  // Reference model: signed-overflow rule, borrow by comparison, bitwise loops for shifts.
  function automatic exp_t model(input logic [N-1:0] ma, mb, input logic [1:0] mc,
                                 input logic mcin, mmode);
    exp_t e;
    logic [2*N-1:0] prod;
    int s;
    e = '0;
    s = int'(mb) % N;
    if (!mmode) begin
      case ({mc, mcin})
        3'b000: begin
          e.f = ma + mb;
          e.cout = (int'(ma) + int'(mb)) > ((1 << N) - 1);
          e.v = (ma[N-1] == mb[N-1]) && (e.f[N-1] != ma[N-1]);
        end
        3'b001: begin
          e.f = ma - mb;
          e.cout = (ma >= mb);
          e.v = (ma[N-1] != mb[N-1]) && (e.f[N-1] != ma[N-1]);
        end
        3'b010:  e.f = ma | mb;
        3'b011:  e.f = ma | ~mb;
        3'b100:  e.f = ma & mb;
        3'b101:  e.f = ma & ~mb;
        3'b110:  e.f = ~ma;
        default: e.f = ~mb;
      endcase
    end else begin
      case ({mc, mcin})
        3'b000: e.f = ma << s;
        3'b001: e.f = ma >> s;
        3'b010: for (int i = 0; i < N; i++) e.f[i] = (i + s < N) ? ma[i+s] : ma[N-1];
        3'b011: for (int i = 0; i < N; i++) e.f[(i+s)%N] = ma[i];
        3'b100: begin
          prod = (2*N)'(ma) * (2*N)'(mb);
          e.f = prod[N-1:0];
          e.cout = (prod[2*N-1:N] != 0);
          e.v = e.cout;
        end
        default: e.f = ma;
      endcase
    end
    e.z = (e.f == 0);
    e.n = e.f[N-1];
    return e;
  endfunction

  // Monitor: pops on every consumed result, and checks stability across stalled cycles.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled && out_valid) check("hold_stable", 32'(dut_res()), 32'(held));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_result", 32'(out_valid), 32'(0));
        end else begin
          popped = sb_q.pop_front();
          check("result", 32'(dut_res()), 32'(popped));
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        held = dut_res();
      end else begin
        stalled = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
  end

  // Presents one operation and returns 1 time unit after the edge that accepted it.
  task automatic issue(input logic [N-1:0] ia, ib, input logic [1:0] ic, input logic icin, imode);
    bit ok;
    ok = 1'b0;
    a = ia; b = ib; ctrl = ic; cin = icin; mode = imode;
    in_valid = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) begin
      check("issue_timeout", 32'(in_ready), 32'(1));
      in_valid = 1'b0;
    end else begin
      sb_q.push_back(model(ia, ib, ic, icin, imode));
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic check_now(input string name, input exp_t e);
    check({name, "_valid"}, 32'(out_valid), 32'(1));
    check(name, 32'(dut_res()), 32'(e));
  endtask

  // Called right after a multiply is accepted: busy for N cycles, then valid.
  task automatic mul_timing(input string name);
    int busy;
    busy = 0;
    for (int i = 0; i < N; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (!in_ready && !out_valid) busy++;
    end
    check({name, "_busy"}, 32'(busy), 32'(N));
    @(posedge clk); #1;
    check({name, "_latency"}, 32'(out_valid), 32'(1));
  endtask

  initial begin
    int c0;
    int good;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_valid, f, cout, v, z, n}), 32'(0));
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", 32'({in_ready, out_valid}), 32'(2'b10));
    out_ready = 1'b1;

    issue(8'h7F, 8'h01, 2'b00, 1'b0, 1'b0); check_now("add_ovf",  mk(8'h80, 0, 1, 0, 1));
    issue(8'h05, 8'h05, 2'b00, 1'b1, 1'b0); check_now("sub_zero", mk(8'h00, 1, 0, 1, 0));
    issue(8'h00, 8'h01, 2'b00, 1'b1, 1'b0); check_now("sub_brw",  mk(8'hFF, 0, 0, 0, 1));
    issue(8'h81, 8'h09, 2'b00, 1'b0, 1'b1); check_now("shl",      mk(8'h02, 0, 0, 0, 0));
    issue(8'h81, 8'h09, 2'b00, 1'b1, 1'b1); check_now("shr",      mk(8'h40, 0, 0, 0, 0));
    issue(8'h81, 8'h09, 2'b01, 1'b0, 1'b1); check_now("asr",      mk(8'hC0, 0, 0, 0, 1));
    issue(8'h81, 8'h09, 2'b01, 1'b1, 1'b1); check_now("rotl",     mk(8'h03, 0, 0, 0, 0));

    c0 = cyc;
    for (int i = 0; i < 4; i++) issue(N'($urandom), N'($urandom), 2'($urandom), 1'($urandom), 1'b0);
    check("back_to_back_cycles", 32'(cyc - c0), 32'(4));

    issue(8'h10, 8'h11, 2'b10, 1'b0, 1'b1);
    mul_timing("mul_a");
    check_now("mul_ovf", mk(8'h10, 1, 1, 0, 0));
    issue(8'h0F, 8'h0F, 2'b10, 1'b0, 1'b1);
    mul_timing("mul_b");
    check_now("mul_e1", mk(8'hE1, 0, 0, 0, 1));

    // Backpressure: AND held while ORN waits, then swapped on one edge.
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'hF0, 8'h3C, 2'b10, 1'b0, 1'b0);
    check_now("and", mk(8'h30, 0, 0, 0, 0));
    a = 8'hF0; b = 8'h3C; ctrl = 2'b01; cin = 1'b1; mode = 1'b0; in_valid = 1'b1;
    good = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!in_ready) good++;
      @(posedge clk); #1;
    end
    check("stall_in_ready", 32'(good), 32'(3));
    check_now("and_held", mk(8'h30, 0, 0, 0, 0));
    out_ready = 1'b1;
    sb_q.push_back(model(8'hF0, 8'h3C, 2'b01, 1'b1, 1'b0));
    @(negedge clk);
    check("release_in_ready", 32'(in_ready), 32'(1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_now("orn", mk(8'hF3, 0, 0, 0, 1));

    // Reset three cycles into a multiply.
    issue(8'h0F, 8'h0F, 2'b10, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_mul", 32'({out_valid, f, cout, v, z, n}), 32'(0));
    check("reset_in_ready", 32'(in_ready), 32'(1));
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    good = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (in_ready && !out_valid) good++;
    end
    check("no_spurious_valid", 32'(good), 32'(4));

    // Randomized traffic with random backpressure.
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      issue(N'($urandom), N'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    for (int t = 0; t < 200 && sb_q.size() != 0; t++) @(posedge clk);
    @(posedge clk); #1;
    check("drain", 32'(sb_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
